strobed_to_axi: RTL and testbench

- Converts a strobed sample interface (one-cycle `in_stb` per valid sample) into an AXI-Stream, the inverse of the strobed output stage.
- Buffers samples in a small internal FIFO and frames them into packets of `spp` samples, or fewer when `in_last` arrives first.
- Reports overflow when the downstream consumer back-pressures longer than the FIFO can absorb.
- Sits directly downstream of strobed producers (radio/DSP cores, strobed AXI sources) and feeds AXI framing logic.

---
 rtl/strobed_to_axi_pkg.sv | 20 ++
 rtl/strobed_to_axi_fifo.sv | 65 ++++++
 rtl/strobed_to_axi.sv | 101 ++++++++++
 tb/tb_strobed_to_axi.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/strobed_to_axi_pkg.sv
// ============================================================================
// strobed_to_axi_pkg : shared constants and helpers for strobed_to_axi
// Revision: 1.0
// ============================================================================
`default_nettype none

package strobed_to_axi_pkg;

   localparam int DROP_COUNT_WIDTH = 16;

   typedef logic [DROP_COUNT_WIDTH-1:0] drop_cnt_t;

   // Saturating increment; the count sticks at all-ones.
   function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
      return (&v) ? v : v + drop_cnt_t'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/strobed_to_axi_fifo.sv
// ============================================================================
// strobed_to_axi_fifo : ring buffer of {tlast,data} with full/empty/occupancy
// Revision: 1.0
// ============================================================================
`default_nettype none

module strobed_to_axi_fifo #(
   parameter int WIDTH     = 33,
   parameter int FIFO_SIZE = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 wr_en_i,
   input  logic [WIDTH-1:0]     wr_data_i,
   input  logic                 rd_en_i,
   output logic [WIDTH-1:0]     rd_data_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic [FIFO_SIZE:0]   occupied_o
);

   localparam int                 DEPTH  = 2**FIFO_SIZE;
   localparam logic [FIFO_SIZE:0] C_FULL = (FIFO_SIZE+1)'(DEPTH);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [FIFO_SIZE-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_SIZE:0]   count_q;
   logic                 wr, rd;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == C_FULL);
   assign occupied_o = count_q;
   assign rd         = rd_en_i & ~empty_o;
   // A full buffer still takes a write when a slot frees in the same cycle.
   assign wr         = wr_en_i & (~full_o | rd);
   assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr, rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/strobed_to_axi.sv
// ============================================================================
// strobed_to_axi : frames a strobed sample stream into AXI-Stream packets
// Revision: 1.0
// ============================================================================
`default_nettype none

module strobed_to_axi
   import strobed_to_axi_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FIFO_SIZE = 5,
   parameter int MAX_SPP   = 4096
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic [$clog2(MAX_SPP):0]   spp,
   input  logic                       in_stb,
   input  logic                       in_last,
   input  logic [WIDTH-1:0]           in_data,
   output logic [WIDTH-1:0]           o_tdata,
   output logic                       o_tlast,
   output logic                       o_tvalid,
   input  logic                       o_tready,
   output logic                       overflow,
   output logic [DROP_COUNT_WIDTH-1:0] drop_count,
   output logic [FIFO_SIZE:0]         occupied
);

   localparam int CW = $clog2(MAX_SPP) + 1;
   typedef logic [CW-1:0] cnt_t;

   cnt_t      counter_q, counter_d;
   cnt_t      spp_q, spp_d;
   cnt_t      spp_eff, spp_sel;
   logic      overflow_q, overflow_d;
   drop_cnt_t drop_q, drop_d;
   logic      full, empty, rd, accept, drop, wr_last;

   // The first sample of a packet compares against the live spp it latches.
   assign spp_eff = (spp == '0) ? cnt_t'(1) : spp;
   assign spp_sel = (counter_q == cnt_t'(1)) ? spp_eff : spp_q;
   assign wr_last = in_last | (counter_q == spp_sel);

   assign o_tvalid = ~empty;
   assign rd       = o_tvalid & o_tready;
   assign accept   = in_stb & (~full | rd);
   assign drop     = in_stb & ~accept;

   always_comb begin
      counter_d  = counter_q;
      spp_d      = spp_q;
      overflow_d = drop;
      drop_d     = drop ? sat_inc(drop_q) : drop_q;
      if (accept) begin
         if (counter_q == cnt_t'(1)) spp_d = spp_eff;
         counter_d = wr_last ? cnt_t'(1) : counter_q + cnt_t'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_q  <= cnt_t'(1);
         spp_q      <= cnt_t'(1);
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (clear) begin
         counter_q  <= cnt_t'(1);
         spp_q      <= cnt_t'(1);
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         counter_q  <= counter_d;
         spp_q      <= spp_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_q;

   strobed_to_axi_fifo #(
      .WIDTH     (WIDTH + 1),
      .FIFO_SIZE (FIFO_SIZE)
   ) u_fifo (
      .clk_i      (clk),
      .rst_i      (reset),
      .clear_i    (clear),
      .wr_en_i    (accept),
      .wr_data_i  ({wr_last, in_data}),
      .rd_en_i    (rd),
      .rd_data_o  ({o_tlast, o_tdata}),
      .full_o     (full),
      .empty_o    (empty),
      .occupied_o (occupied)
   );

endmodule

`default_nettype wire

// File: tb/tb_strobed_to_axi.sv
// ============================================================================
// tb_strobed_to_axi : scoreboard bench with a packet-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_strobed_to_axi;

   localparam int W     = 16;
   localparam int FS    = 2;
   localparam int DEPTH = 4;
   localparam int MSPP  = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear = 1'b0;
   logic [4:0]    spp = 5'd4;
   logic          stb = 1'b0, last = 1'b0, ready = 1'b0;
   logic [W-1:0]  data = '0;
   logic [W-1:0]  o_tdata;
   logic          o_tlast, o_tvalid, overflow;
   logic [15:0]   drop_count;
   logic [FS:0]   occupied;

   strobed_to_axi #(.WIDTH(W), .FIFO_SIZE(FS), .MAX_SPP(MSPP)) dut (
      .clk(clk), .reset(reset), .clear(clear), .spp(spp),
      .in_stb(stb), .in_last(last), .in_data(data),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
      .o_tready(ready), .overflow(overflow), .drop_count(drop_count),
      .occupied(occupied)
   );

   always #5 clk = ~clk;

   typedef struct { bit last; logic [W-1:0] data; } beat_t;
   beat_t expq[$];
   int  m_occ = 0, m_n = 0, m_len = 1, m_drops = 0;
   bit  m_ovf = 0;
   int  checks = 0, errors = 0;
   bit  done = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_occ = 0; m_n = 0; m_len = 1; m_ovf = 0; m_drops = 0;
      expq.delete();
   endtask

   // Applies the edge that just happened, using the inputs held across it.
   task automatic commit();
      bit rd, acc, tl;
      if (reset || clear) begin
         model_reset();
         return;
      end
      rd  = (m_occ > 0) && ready;
      acc = stb && (m_occ < DEPTH || rd);
      if (acc) begin
         if (m_n == 0) m_len = (spp == 0) ? 1 : int'(spp);
         m_n++;
         tl = last || (m_n == m_len);
         expq.push_back('{tl, data});
         if (tl) m_n = 0;
      end
      m_ovf = stb && !acc;
      if (m_ovf && m_drops < 65535) m_drops++;
      m_occ = m_occ + int'(acc) - int'(rd);
   endtask

   task automatic step(input bit s, input bit l, input logic [W-1:0] d, input bit r);
      @(posedge clk); #1;
      commit();
      stb = s; last = l; data = d; ready = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, 1);
   endtask

   always @(negedge clk) begin
      if (!done) begin
         chk("tvalid", int'(o_tvalid), int'(m_occ > 0));
         chk("occupied", int'(occupied), m_occ);
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("drop_count", int'(drop_count), m_drops);
         if (o_tvalid) begin
            if (expq.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               chk("tdata", int'(o_tdata), int'(expq[0].data));
               chk("tlast", int'(o_tlast), int'(expq[0].last));
               if (ready) void'(expq.pop_front());
            end
         end
      end
   end

   initial begin
      int k;
      repeat (3) step(0, 0, '0, 0);
      reset = 1'b0;
      chk("rst_tdata", int'(o_tdata), 0);
      chk("rst_tlast", int'(o_tlast), 0);

      // basic framing
      spp = 5'd4;
      for (int i = 0; i < 10; i++) step(1, 0, W'(16'h100 + i), 1);
      idle(4);

      // early last then counter resumes
      spp = 5'd8;
      for (int i = 0; i < 14; i++) step(1, (i == 2), W'(16'h200 + i), 1);
      idle(4);

      // overflow under back-pressure, dropped sample carries in_last
      spp = 5'd3;
      for (int i = 0; i < 6; i++) step(1, (i == 5), W'(16'h300 + i), 0);
      step(0, 0, '0, 0);
      idle(8);

      // full buffer with simultaneous read every cycle
      for (int i = 0; i < 4; i++) step(1, 0, W'(16'h400 + i), 0);
      for (int i = 0; i < 10; i++) step(1, 0, W'(16'h410 + i), 1);
      idle(6);

      // spp change mid-packet, then spp=0
      spp = 5'd4;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) spp = 5'd2;
         step(1, 0, W'(16'h500 + i), 1);
      end
      spp = 5'd0;
      for (int i = 0; i < 5; i++) step(1, 0, W'(16'h600 + i), 1);
      idle(4);

      // async reset with a partial packet buffered
      spp = 5'd4;
      for (int i = 0; i < 3; i++) step(1, 0, W'(16'h700 + i), 0);
      step(0, 0, '0, 0);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("arst_tvalid", int'(o_tvalid), 0);
      chk("arst_drop_count", int'(drop_count), 0);
      chk("arst_occupied", int'(occupied), 0);
      chk("arst_tdata", int'(o_tdata), 0);
      step(0, 0, '0, 1);
      step(0, 0, '0, 1);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) step(1, 0, W'(16'h800 + i), 1);
      idle(4);

      // randomized traffic with occasional clear and spp changes
      for (int i = 0; i < 600; i++) begin
         k = $urandom_range(0, 99);
         if (k < 5) spp = 5'($urandom_range(0, 8));
         clear = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15,
              W'($urandom), $urandom_range(0, 99) < 55);
         clear = 1'b0;
      end

      for (int i = 0; i < 50 && m_occ > 0; i++) step(0, 0, '0, 1);
      chk("drain_empty", m_occ, 0);
      idle(2);
      chk("queue_empty", expq.size(), 0);
      done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
